// File: rtl/periph_demux_pkg.sv
// Shared constants and helpers for the peripheral demultiplexer.
// Default peripheral window, target-index field and counter sizing.
package periph_demux_pkg;

  localparam int unsigned REGION_LSB_DEF = 14;
  localparam int unsigned REGION_W_DEF   = 6;
  localparam logic [5:0]  REGION_ID_DEF  = 6'b000001;
  localparam int unsigned IDX_LSB_DEF    = 10;
  localparam int unsigned IDX_W_DEF      = 4;

  function automatic int unsigned cnt_width(input int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/periph_demux_n_if.sv
// Core-side request/response bus plus the per-target fan-out bus.
// slave is the demux view; master is the core/target environment view.
interface periph_demux_n_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned NUM_PORTS  = 5
);

  logic                                  data_req_i;
  logic [ADDR_WIDTH-1:0]                 data_add_i;
  logic                                  data_wen_i;
  logic [DATA_WIDTH-1:0]                 data_wdata_i;
  logic [BE_WIDTH-1:0]                   data_be_i;
  logic                                  data_gnt_o;
  logic                                  data_r_valid_o;
  logic [DATA_WIDTH-1:0]                 data_r_rdata_o;
  logic                                  data_r_opc_o;

  logic [NUM_PORTS-1:0]                  per_req_o;
  logic [ADDR_WIDTH-1:0]                 per_add_o;
  logic                                  per_wen_o;
  logic [DATA_WIDTH-1:0]                 per_wdata_o;
  logic [BE_WIDTH-1:0]                   per_be_o;
  logic [NUM_PORTS-1:0]                  per_gnt_i;
  logic [NUM_PORTS-1:0]                  per_r_valid_i;
  logic [NUM_PORTS-1:0]                  per_r_opc_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  per_r_rdata_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    input  per_gnt_i, per_r_valid_i, per_r_opc_i, per_r_rdata_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    output per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    output per_gnt_i, per_r_valid_i, per_r_opc_i, per_r_rdata_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    input  per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o
  );

endinterface

// File: rtl/periph_outst_tracker.sv
// Outstanding-request counter and destination register for the demux.
// A response retires only when something is outstanding and it comes from the current target.
module periph_outst_tracker
  import periph_demux_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter int unsigned CNT_W     = cnt_width(MAX_OUTST)
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 accept_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [NUM_PORTS-1:0] per_r_valid_i,
  output logic [IDX_W-1:0]     dest_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 retire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] dest_q, dest_d;
  logic             w_dest_valid;

  always_comb begin
    w_dest_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (dest_q == IDX_W'(i)) w_dest_valid = per_r_valid_i[i];
    end
  end

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CNT_W'(MAX_OUTST));
  assign retire_o = !empty_o && w_dest_valid;
  assign dest_o   = dest_q;

  always_comb begin
    cnt_d  = cnt_q;
    dest_d = accept_i ? idx_i : dest_q;
    unique case ({accept_i, retire_o})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      dest_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dest_q <= dest_d;
    end
  end

endmodule

// File: rtl/periph_demux_n.sv
// Address-decoded demux from one core data port to NUM_PORTS peripheral targets.
// Unmapped accesses get a one-cycle-late error response; mapped responses pass through in order.
module periph_demux_n
  import periph_demux_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned          NUM_PORTS  = 5,
  parameter int unsigned          MAX_OUTST  = 4,
  parameter int unsigned          REGION_LSB = REGION_LSB_DEF,
  parameter int unsigned          REGION_W   = REGION_W_DEF,
  parameter logic [REGION_W-1:0]  REGION_ID  = REGION_ID_DEF,
  parameter int unsigned          IDX_LSB    = IDX_LSB_DEF,
  parameter int unsigned          IDX_W      = IDX_W_DEF
) (
  input logic             clk,
  input logic             rst_i,
  periph_demux_n_if.slave bus
);

  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_dest;
  logic                  w_mapped;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_retire;
  logic                  w_can_issue;
  logic                  w_sel_gnt;
  logic                  w_sel_opc;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic [NUM_PORTS-1:0]  w_per_req;
  logic                  w_accept;
  logic                  err_q;

  assign w_idx    = bus.data_add_i[IDX_LSB +: IDX_W];
  assign w_mapped = (bus.data_add_i[REGION_LSB +: REGION_W] == REGION_ID) &&
                    (32'(w_idx) < NUM_PORTS);

  // A full tracker may still issue when the same cycle retires a response.
  assign w_can_issue = w_empty || ((!w_full || w_retire) && (w_idx == w_dest));

  always_comb begin
    w_per_req   = '0;
    w_sel_gnt   = 1'b0;
    w_sel_opc   = 1'b0;
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_per_req[i] = bus.data_req_i && w_mapped && w_can_issue;
        w_sel_gnt    = bus.per_gnt_i[i];
      end
      if (w_dest == IDX_W'(i)) begin
        w_sel_opc   = bus.per_r_opc_i[i];
        w_sel_rdata = bus.per_r_rdata_i[i];
      end
    end
  end

  assign w_accept = bus.data_req_i && w_mapped && w_can_issue && w_sel_gnt;

  assign bus.per_req_o   = w_per_req;
  assign bus.per_add_o   = bus.data_add_i;
  assign bus.per_wen_o   = bus.data_wen_i;
  assign bus.per_wdata_o = bus.data_wdata_i;
  assign bus.per_be_o    = bus.data_be_i;

  assign bus.data_gnt_o = w_mapped ? (w_can_issue && w_sel_gnt) : (bus.data_req_i && w_empty);

  assign bus.data_r_valid_o = err_q || w_retire;
  assign bus.data_r_opc_o   = err_q || (w_retire && w_sel_opc);
  assign bus.data_r_rdata_o = (!err_q && w_retire) ? w_sel_rdata : '0;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= bus.data_req_i && !w_mapped && w_empty;
  end

  periph_outst_tracker #(
    .NUM_PORTS (NUM_PORTS),
    .MAX_OUTST (MAX_OUTST),
    .IDX_W     (IDX_W)
  ) u_trk (
    .clk           (clk),
    .rst_i         (rst_i),
    .accept_i      (w_accept),
    .idx_i         (w_idx),
    .per_r_valid_i (bus.per_r_valid_i),
    .dest_o        (w_dest),
    .empty_o       (w_empty),
    .full_o        (w_full),
    .retire_o      (w_retire)
  );

endmodule

// File: tb/tb_periph_demux_n.sv
// Scoreboard bench for periph_demux_n: stimulus pushes expected responses,
// a negedge monitor pops and compares every data_r_valid_o beat.
module tb_periph_demux_n;

  localparam int unsigned NP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  periph_demux_n_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BE_WIDTH   (4),
    .NUM_PORTS  (NP)
  ) bus ();

  periph_demux_n #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BE_WIDTH   (4),
    .NUM_PORTS  (NP),
    .MAX_OUTST  (4)
  ) dut (
    .clk   (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        opc;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (bus.data_r_valid_o) begin
      if (sb_q.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_opc", 32'(bus.data_r_opc_o), 32'(e.opc));
        check("resp_rdata", bus.data_r_rdata_o, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.data_req_i    = 1'b0;
    bus.data_add_i    = '0;
    bus.data_wen_i    = 1'b0;
    bus.data_wdata_i  = '0;
    bus.data_be_i     = '0;
    bus.per_r_valid_i = '0;
    bus.per_r_opc_i   = '0;
  endtask

  task automatic req(input logic [31:0] addr, input logic wen);
    bus.data_req_i   = 1'b1;
    bus.data_add_i   = addr;
    bus.data_wen_i   = wen;
    bus.data_wdata_i = addr ^ 32'hFFFF_0000;
    bus.data_be_i    = 4'hF;
  endtask

  task automatic resp(input int p, input logic [31:0] d, input logic opc);
    bus.per_r_valid_i    = NP'(1 << p);
    bus.per_r_opc_i      = opc ? NP'(1 << p) : '0;
    bus.per_r_rdata_i[p] = d;
  endtask

  task automatic push(input logic opc, input logic [31:0] d);
    exp_t e;
    e.opc   = opc;
    e.rdata = d;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] a_of(input int idx);
    return 32'h1020_4000 | (32'(idx) << 10);
  endfunction

  function automatic logic [31:0] rd(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] cnt();
    return 32'(dut.u_trk.cnt_q);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.per_gnt_i     = '1;
    bus.per_r_rdata_i = '0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state; decode stays combinational while reset is held
    req(a_of(2), 1'b0);
    samp();
    check("rst_rvalid", 32'(bus.data_r_valid_o), 32'd0);
    check("rst_opc", 32'(bus.data_r_opc_o), 32'd0);
    check("rst_rdata", bus.data_r_rdata_o, 32'd0);
    check("rst_cnt", cnt(), 32'd0);
    check("rst_per_req", 32'(bus.per_req_o), 32'b00100);
    check("rst_gnt", 32'(bus.data_gnt_o), 32'd1);
    tick();
    idle();
    rst = 1'b0;

    // Write to idx 2: grant follows per_gnt_i[2], response one cycle later
    tick();
    bus.per_gnt_i = '0;
    req(32'h1020_4800, 1'b1);
    samp();
    check("t1_per_req_wait", 32'(bus.per_req_o), 32'b00100);
    check("t1_gnt_wait", 32'(bus.data_gnt_o), 32'd0);
    tick();
    bus.per_gnt_i = '1;
    samp();
    check("t1_per_req", 32'(bus.per_req_o), 32'b00100);
    check("t1_gnt", 32'(bus.data_gnt_o), 32'd1);
    check("t1_per_add", bus.per_add_o, 32'h1020_4800);
    check("t1_per_wen", 32'(bus.per_wen_o), 32'd1);
    push(1'b0, 32'hA5A5_0002);
    tick();
    idle();
    resp(2, 32'hA5A5_0002, 1'b0);
    samp();
    check("t1_rvalid", 32'(bus.data_r_valid_o), 32'd1);
    tick();
    idle();
    samp();
    check("t1_cnt", cnt(), 32'd0);

    // Four outstanding reads to idx 1; fifth stalls until the first response
    for (int k = 0; k < 4; k++) begin
      tick();
      req(a_of(1), 1'b0);
      samp();
      check("t2_gnt", 32'(bus.data_gnt_o), 32'd1);
      push(1'b0, rd(k));
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      samp();
      check("t2_stall_gnt", 32'(bus.data_gnt_o), 32'd0);
      check("t2_stall_req", 32'(bus.per_req_o), 32'd0);
    end
    tick();
    resp(1, rd(0), 1'b0);
    samp();
    check("t2_retire_gnt", 32'(bus.data_gnt_o), 32'd1);
    check("t2_retire_req", 32'(bus.per_req_o), 32'b00010);
    push(1'b0, rd(4));
    tick();
    idle();
    samp();
    check("t2_cnt_full", cnt(), 32'd4);
    for (int k = 1; k < 5; k++) begin
      tick();
      resp(1, rd(k), 1'b0);
      samp();
    end
    tick();
    idle();
    samp();
    check("t2_cnt_drained", cnt(), 32'd0);

    // Read to idx 1 outstanding; idx 3 waits for the count to reach zero
    tick();
    req(a_of(1), 1'b0);
    samp();
    check("t3_gnt_first", 32'(bus.data_gnt_o), 32'd1);
    push(1'b0, rd(10));
    tick();
    req(a_of(3), 1'b0);
    samp();
    check("t3_stall_gnt", 32'(bus.data_gnt_o), 32'd0);
    check("t3_stall_req", 32'(bus.per_req_o), 32'd0);
    tick();
    resp(1, rd(10), 1'b0);
    samp();
    check("t3_retire_stall_gnt", 32'(bus.data_gnt_o), 32'd0);
    check("t3_retire_stall_req", 32'(bus.per_req_o), 32'd0);
    tick();
    bus.per_r_valid_i = '0;
    samp();
    check("t3_issue_req", 32'(bus.per_req_o), 32'b01000);
    check("t3_issue_gnt", 32'(bus.data_gnt_o), 32'd1);
    push(1'b0, rd(11));
    tick();
    idle();
    resp(3, rd(11), 1'b0);
    samp();
    tick();
    idle();
    samp();
    check("t3_cnt", cnt(), 32'd0);

    // Unmapped: index beyond NUM_PORTS, then out-of-region, back-to-back
    tick();
    req(32'h1020_7C00, 1'b0);
    samp();
    check("t4_idx15_gnt", 32'(bus.data_gnt_o), 32'd1);
    check("t4_idx15_req", 32'(bus.per_req_o), 32'd0);
    push(1'b1, 32'd0);
    tick();
    req(32'h1030_0000, 1'b1);
    samp();
    check("t4_region_gnt", 32'(bus.data_gnt_o), 32'd1);
    check("t4_region_req", 32'(bus.per_req_o), 32'd0);
    check("t4_err1_rvalid", 32'(bus.data_r_valid_o), 32'd1);
    push(1'b1, 32'd0);
    tick();
    idle();
    samp();
    check("t4_err2_rvalid", 32'(bus.data_r_valid_o), 32'd1);
    tick();
    samp();
    check("t4_quiet", 32'(bus.data_r_valid_o), 32'd0);

    // Accept and retire together at count 2; spurious response from idx 4
    for (int k = 0; k < 2; k++) begin
      tick();
      req(a_of(1), 1'b0);
      samp();
      push(1'b0, rd(20 + k));
    end
    tick();
    req(a_of(1), 1'b0);
    resp(1, rd(20), 1'b0);
    samp();
    check("t5_both_gnt", 32'(bus.data_gnt_o), 32'd1);
    push(1'b0, rd(22));
    tick();
    idle();
    samp();
    check("t5_cnt_same", cnt(), 32'd2);
    tick();
    resp(4, 32'hDEAD_BEEF, 1'b1);
    samp();
    check("t5_spurious", 32'(bus.data_r_valid_o), 32'd0);
    tick();
    idle();
    req(32'h1030_0000, 1'b0);
    samp();
    check("t5_unmapped_busy_gnt", 32'(bus.data_gnt_o), 32'd0);
    for (int k = 1; k < 3; k++) begin
      tick();
      idle();
      resp(1, rd(20 + k), 1'b0);
      samp();
    end
    tick();
    idle();
    samp();
    check("t5_cnt_drained", cnt(), 32'd0);

    // Reset with three outstanding; the late response must be dropped
    for (int k = 0; k < 3; k++) begin
      tick();
      req(a_of(1), 1'b0);
      samp();
      push(1'b0, rd(30 + k));
    end
    tick();
    idle();
    samp();
    check("t6_cnt_3", cnt(), 32'd3);
    tick();
    rst = 1'b1;
    samp();
    check("t6_rst_cnt", cnt(), 32'd0);
    check("t6_rst_rvalid", 32'(bus.data_r_valid_o), 32'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    resp(1, rd(30), 1'b0);
    samp();
    check("t6_late_rvalid", 32'(bus.data_r_valid_o), 32'd0);
    check("t6_late_cnt", cnt(), 32'd0);
    tick();
    idle();
    samp();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
